// File: rtl/mac_psum_acc.sv
`default_nettype none
// ============================================================================
// Module   : mac_psum_acc
// Purpose  : Partial-sum accumulator sitting behind a mac_wrapper. The
//            upstream wrapper adds its tile dot product to psum_fb and
//            returns the result on mac_out. This block keeps that running
//            value and counts tiles. After num_tiles beats it presents the
//            completed sum on out_data with a valid/ready handshake.
// Ports    : clk, reset      - single clock, synchronous active-high reset
//            num_tiles       - tiles per output (0 means 1), sampled on the
//                              first beat only
//            in_valid/in_ready, mac_out - tile result stream from wrapper
//            psum_fb         - running accumulator fed back to wrapper
//            out_valid/out_ready, out_data - completed sum stream
//            tile_cnt        - beats accepted in the current accumulation
// Config   : PSUM_RELU_EN    - when defined, negative final sums are
//                              latched into out_data as zero
// Revision : 1.0 - initial release
// ============================================================================
module mac_psum_acc #(
    parameter int psum_bw = 16,
    parameter int cnt_bw  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [cnt_bw-1:0]  num_tiles,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [psum_bw-1:0] mac_out,
    output logic [psum_bw-1:0] psum_fb,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [psum_bw-1:0] out_data,
    output logic [cnt_bw-1:0]  tile_cnt
);

    localparam logic [cnt_bw-1:0] c_one = cnt_bw'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [psum_bw-1:0]  r_acc;
    logic [psum_bw-1:0]  r_out_data;
    logic [cnt_bw-1:0]   r_tile_cnt;
    logic [cnt_bw-1:0]   r_ntiles;

    logic                w_accept;
    logic                w_last;
    logic [cnt_bw-1:0]   w_ntiles_in;
    logic [cnt_bw-1:0]   w_cnt_inc;
    logic [psum_bw-1:0]  w_final;

    // in_ready is forced high while reset is held so the reset cycle looks
    // like IDLE to the producer; w_accept still masks the beat out.
    assign in_ready    = reset || (r_state != S_HOLD);
    assign w_accept    = in_valid && in_ready && !reset;
    assign w_ntiles_in = (num_tiles == '0) ? c_one : num_tiles;
    assign w_cnt_inc   = r_tile_cnt + c_one;

    assign psum_fb     = r_acc;
    assign out_valid   = (r_state == S_HOLD);
    assign out_data    = r_out_data;
    assign tile_cnt    = r_tile_cnt;

    // Rectification applies only to the latched result, never to feedback.
`ifdef PSUM_RELU_EN
    assign w_final = mac_out[psum_bw-1] ? '0 : mac_out;
`else
    assign w_final = mac_out;
`endif

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_last      = (w_ntiles_in == c_one);
                    w_state_nxt = w_last ? S_HOLD : S_ACC;
                end
            end
            S_ACC: begin
                if (w_accept) begin
                    w_last      = (w_cnt_inc == r_ntiles);
                    w_state_nxt = w_last ? S_HOLD : S_ACC;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_out_data <= '0;
            r_tile_cnt <= '0;
            r_ntiles   <= c_one;
        end else if (w_accept) begin
            if (r_state == S_IDLE) begin
                // num_tiles is only looked at here, so later changes are inert
                r_ntiles   <= w_ntiles_in;
                r_tile_cnt <= c_one;
            end else begin
                r_tile_cnt <= w_cnt_inc;
            end
            if (w_last) begin
                // Accumulator is cleared so psum_fb reads 0 while holding
                r_acc      <= '0;
                r_out_data <= w_final;
            end else begin
                r_acc      <= mac_out;
            end
        end else if ((r_state == S_HOLD) && out_ready) begin
            r_tile_cnt <= '0;
        end
    end

endmodule
`default_nettype wire

// File: doc/mac_psum_acc.md
MAC_PSUM_ACC -- requirements
Module: mac_psum_acc

Interface
REQ-001 SHALL have parameter psum_bw, default 16, giving the partial-sum width in two's complement.
REQ-002 SHALL have parameter cnt_bw, default 4, giving the tile-count width.
REQ-003 SHALL have port clk  input  1  as its single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  as a synchronous, active-high reset.
REQ-005 SHALL have port num_tiles  input  cnt_bw  giving the tiles per output, sampled on the first accepted beat.
REQ-006 SHALL have port in_valid  input  1  meaning mac_out holds a valid tile result.
REQ-007 SHALL have port in_ready  output  1  meaning the block accepts mac_out this cycle.
REQ-008 SHALL have port mac_out  input  psum_bw  carrying the upstream mac_wrapper result (tile dot product + psum_fb).
REQ-009 SHALL have port psum_fb  output  psum_bw  carrying the running accumulator, fed to mac_wrapper psum_in.
REQ-010 SHALL have port out_valid  output  1  meaning out_data holds a completed sum.
REQ-011 SHALL have port out_ready  input  1  meaning the consumer takes out_data this cycle.
REQ-012 SHALL have port out_data  output  psum_bw  carrying the completed accumulated sum.
REQ-013 SHALL have port tile_cnt  output  cnt_bw  giving the beats accepted in the current accumulation.

Function
REQ-014 SHALL implement states IDLE, ACC and HOLD.
REQ-015 Accept = in_valid && in_ready; in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD.
REQ-016 psum_fb SHALL equal the accumulator register, which is 0 in IDLE and HOLD.
REQ-017 IDLE on accept: latch num_tiles into ntiles_q (0 treated as 1), acc <= mac_out, tile_cnt <= 1; go to HOLD if ntiles_q == 1, else go to ACC.
REQ-018 ACC on accept: acc <= mac_out and tile_cnt += 1; when the new tile_cnt == ntiles_q, set out_data <= mac_out (after the optional ReLU), clear acc and go to HOLD.
REQ-019 ACC with no accept SHALL hold acc and tile_cnt with no timeout.
REQ-020 Result latency SHALL be one cycle: out_valid rises on the edge that accepts the final beat.
REQ-021 HOLD: out_valid = 1, and out_data SHALL stay stable until out_valid && out_ready.
REQ-022 HOLD on out_ready: go to IDLE, out_valid <= 0, tile_cnt <= 0 (one-cycle bubble before the next accept).
REQ-023 Accumulation SHALL wrap modulo 2^psum_bw, since the addition is performed upstream.
REQ-024 Changes to num_tiles during ACC or HOLD SHALL be ignored.
REQ-025 in_valid during HOLD SHALL be ignored, and no data SHALL be lost because in_ready = 0.

Reset
REQ-026 reset SHALL force state IDLE, acc = 0, psum_fb = 0, tile_cnt = 0, ntiles_q = 1, out_valid = 0, out_data = 0.
REQ-027 In a reset cycle in_ready SHALL be 1 but no beat SHALL be accepted; reset overrides simultaneous accept or out_ready.
REQ-028 Reset mid-accumulation or in HOLD SHALL discard the partial or pending result silently.

Configuration
REQ-029 Macro PSUM_RELU_EN SHALL control output rectification.
REQ-030 With PSUM_RELU_EN defined, a final sum with MSB = 1 SHALL be latched into out_data as 0; psum_fb SHALL never be rectified.
REQ-031 With PSUM_RELU_EN undefined, out_data SHALL be the raw wrapped sum.

Verification
REQ-032 Reset: assert reset 2 cycles -> out_valid=0, in_ready=1, psum_fb=0, tile_cnt=0, out_data=0.
REQ-033 num_tiles=3; model returns mac_out = psum_fb + S with S = 5, 7, -2 on consecutive beats -> psum_fb = 0, 5, 12; out_data=0x000A, out_valid=1 the cycle after beat 3, tile_cnt=3.
REQ-034 Backpressure: complete a sum of 0x0010 with out_ready=0 for 5 cycles -> out_data held at 0x0010, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-035 num_tiles=0; single beat mac_out=0x0009 -> HOLD immediately, out_data=0x0009.
REQ-036 num_tiles=2; S = -10, +4 -> with PSUM_RELU_EN out_data=0x0000, without it out_data=0xFFFA; psum_fb=0xFFF6 between the beats in both builds.
REQ-037 num_tiles=4; reset after beat 2 (acc=0x0020) -> acc=0, tile_cnt=0; next 4-beat run of S=1 each -> out_data=0x0004.
